vga_plot_arbiter: RTL



---
 rtl/vga_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 28 ++
 rtl/vga_plot_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/vga_arb_pkg.sv
// Shared geometry, widths and FSM state type for the VGA plot arbiter.
package vga_arb_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);
    localparam logic [X_W-1:0] X_LIM  = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0] Y_LIM  = Y_W'(SCREEN_H);

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of eligible_i at or above
// rr_ptr_i, wrapping around.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic               valid_o,
    output logic [PTR_W-1:0]   winner_o
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        valid_o  = 1'b0;
        winner_o = rr_ptr_i;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr_i) + k) % NUM_REQ);
            if (!valid_o && eligible_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter for the VGA adapter pixel port with power-up/commanded
// full-screen clear. Define VGA_ARB_BOUNDS_CHECK_EN to suppress off-screen plots.
module vga_plot_arbiter
    import vga_arb_pkg::*;
#(
    parameter int                  NUM_REQ      = 4,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = 3'b000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*X_W-1:0]       req_x,
    input  logic [NUM_REQ*Y_W-1:0]       req_y,
    input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
    input  logic                         clear_req,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [X_W-1:0]               x,
    output logic [Y_W-1:0]               y,
    output logic [COLOUR_W-1:0]          colour,
    output logic                         plot,
    output logic                         busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e           state_q;
    logic [X_W-1:0]       sx_q;
    logic [Y_W-1:0]       sy_q;
    logic [PTR_W-1:0]     rr_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [X_W-1:0]       x_q;
    logic [Y_W-1:0]       y_q;
    logic [COLOUR_W-1:0]  colour_q;
    logic                 plot_q;
    logic                 busy_q;

    logic [X_W-1:0]       rx [NUM_REQ];
    logic [Y_W-1:0]       ry [NUM_REQ];
    logic [COLOUR_W-1:0]  rc [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign rx[g] = req_x[g*X_W +: X_W];
        assign ry[g] = req_y[g*Y_W +: Y_W];
        assign rc[g] = req_colour[g*COLOUR_W +: COLOUR_W];
    end

    // Last cycle's grantee still shows req high with stale data; mask it once.
    logic [NUM_REQ-1:0] eligible_d;
    logic               win_valid;
    logic [PTR_W-1:0]   win;
    logic               in_bounds;

    assign eligible_d = req & ~gnt_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .eligible_i (eligible_d),
        .rr_ptr_i   (rr_q),
        .valid_o    (win_valid),
        .winner_o   (win)
    );

`ifdef VGA_ARB_BOUNDS_CHECK_EN
    assign in_bounds = (rx[win] < X_LIM) && (ry[win] < Y_LIM);
`else
    assign in_bounds = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= CLEAR;
            sx_q     <= '0;
            sy_q     <= '0;
            rr_q     <= '0;
            gnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    gnt_q    <= '0;
                    plot_q   <= 1'b1;
                    colour_q <= CLEAR_COLOUR;
                    x_q      <= sx_q;
                    y_q      <= sy_q;
                    if (sx_q == X_LAST) begin
                        sx_q <= '0;
                        if (sy_q == Y_LAST) begin
                            sy_q    <= '0;
                            state_q <= ARB;
                            busy_q  <= 1'b0;
                        end else begin
                            sy_q <= sy_q + 1'b1;
                        end
                    end else begin
                        sx_q <= sx_q + 1'b1;
                    end
                end
                ARB: begin
                    if (clear_req) begin
                        state_q <= CLEAR;
                        sx_q    <= '0;
                        sy_q    <= '0;
                        busy_q  <= 1'b1;
                        gnt_q   <= '0;
                        plot_q  <= 1'b0;
                    end else if (win_valid) begin
                        gnt_q  <= NUM_REQ'(1) << win;
                        rr_q   <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                        plot_q <= in_bounds;
                        if (in_bounds) begin
                            x_q      <= rx[win];
                            y_q      <= ry[win];
                            colour_q <= rc[win];
                        end
                    end else begin
                        gnt_q  <= '0;
                        plot_q <= 1'b0;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;

endmodule
